// File: rtl/clock_generator_pkg.sv
// clock_generator_pkg: shared constants for the programmable pulse generator
package clock_generator_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int WATCH_COMPARAND = 50_000_000;
endpackage

// File: rtl/clock_generator.sv
// clock_generator: emits a one-cycle pulse every COMPARAND enabled clock cycles
module clock_generator
  import clock_generator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             Enable,
  input  logic [WIDTH-1:0] COMPARAND,
  output logic [WIDTH-1:0] internalCounter,
  output logic             generatedCLOCK
);
  logic [WIDTH-1:0] last;
  logic wrap;
  // zero and one both mean divide-by-one, so guard the decrement against underflow
  assign last = (COMPARAND == '0) ? '0 : COMPARAND - WIDTH'(1);
  assign wrap = internalCounter >= last;
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      internalCounter <= '0;
      generatedCLOCK  <= 1'b0;
    end else begin
      internalCounter <= !Enable ? internalCounter : wrap ? '0 : internalCounter + WIDTH'(1);
      generatedCLOCK  <= Enable && wrap;
    end
  end
endmodule

// File: tb/tb_clock_generator.sv
// tb_clock_generator: directed self-checking bench for clock_generator
module tb_clock_generator;
  logic        CLOCK;
  logic        RESET_N;
  logic        Enable;
  logic [31:0] COMPARAND;
  logic [31:0] internalCounter;
  logic        generatedCLOCK;
  int checks = 0;
  int errors = 0;

  clock_generator #(.WIDTH(32)) dut (
    .CLOCK(CLOCK),
    .RESET_N(RESET_N),
    .Enable(Enable),
    .COMPARAND(COMPARAND),
    .internalCounter(internalCounter),
    .generatedCLOCK(generatedCLOCK)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [31:0] cnt, input logic gen);
    checks++;
    if (internalCounter !== cnt || generatedCLOCK !== gen) begin
      errors++;
      $display("FAIL %s: got cnt=%0d gen=%b, want cnt=%0d gen=%b",
               name, internalCounter, generatedCLOCK, cnt, gen);
    end
  endtask

  task automatic restart(input logic [31:0] cmp, input logic en);
    @(negedge CLOCK);
    RESET_N = 1'b0;
    Enable = en;
    COMPARAND = cmp;
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    Enable = 1'b1;
    COMPARAND = 32'd5;
    repeat (2) step();
    expect_state("reset_hold", 32'd0, 1'b0);
  endtask

  task automatic test_basic();
    restart(32'd5, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step();
      expect_state($sformatf("basic_edge%0d", k), 32'(k % 5), (k % 5) == 0);
    end
  endtask

  task automatic test_enable_gap();
    restart(32'd5, 1'b1);
    repeat (2) step();
    expect_state("gap_pre", 32'd2, 1'b0);
    Enable = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      expect_state($sformatf("gap_hold%0d", k), 32'd2, 1'b0);
    end
    Enable = 1'b1;
    step();
    expect_state("gap_resume1", 32'd3, 1'b0);
    step();
    expect_state("gap_resume2", 32'd4, 1'b0);
    step();
    expect_state("gap_pulse", 32'd0, 1'b1);
    Enable = 1'b0;
    step();
    expect_state("gap_pulse_drop", 32'd0, 1'b0);
    Enable = 1'b1;
    step();
    expect_state("gap_after_drop", 32'd1, 1'b0);
  endtask

  task automatic test_async_reset();
    restart(32'd5, 1'b1);
    repeat (3) step();
    expect_state("async_pre", 32'd3, 1'b0);
    #2 RESET_N = 1'b0;
    #1 expect_state("async_mid_count", 32'd0, 1'b0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      expect_state($sformatf("async_release%0d", k), 32'(k % 5), k == 5);
    end
    #2 RESET_N = 1'b0;
    #1 expect_state("async_mid_pulse", 32'd0, 1'b0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  task automatic test_comparand_change();
    restart(32'd10, 1'b1);
    repeat (7) step();
    expect_state("cmp_pre", 32'd7, 1'b0);
    COMPARAND = 32'd4;
    step();
    expect_state("cmp_wrap", 32'd0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      expect_state($sformatf("cmp_period%0d", k), 32'(k % 4), (k % 4) == 0);
    end
  endtask

  task automatic test_unity();
    restart(32'd1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      expect_state($sformatf("unity_one%0d", k), 32'd0, 1'b1);
    end
    COMPARAND = 32'd0;
    for (int k = 1; k <= 3; k++) begin
      step();
      expect_state($sformatf("unity_zero%0d", k), 32'd0, 1'b1);
    end
    Enable = 1'b0;
    step();
    expect_state("unity_disabled", 32'd0, 1'b0);
  endtask

  task automatic test_long_period();
    int n;
    restart(32'd1000, 1'b1);
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!generatedCLOCK && n < 2000);
      checks++;
      if (n != 1000) begin
        errors++;
        $display("FAIL long_period%0d: got spacing=%0d, want 1000", p, n);
      end
    end
    restart(32'd50_000_000, 1'b1);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (generatedCLOCK) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL watch_no_early_pulse: got pulses=%0d, want 0", n);
    end
    expect_state("watch_count", 32'd200, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable_gap();
    test_async_reset();
    test_comparand_change();
    test_unity();
    test_long_period();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
